cntb_arbiter: RTL and testbench

Shares one bit-run counter unit (cntb: start/word/index in, registered done plus result out) between NUM_REQ requesters, e.g. the core custom-instruction port and a debug/DMA client. Uses round-robin arbitration over valid/ready request channels. Latches the winning operands and holds them stable at the counter for the whole operation. Returns the result on a per-requester valid/ready response channel, with a watchdog in case the counter never signals done.

---
 rtl/cntb_arbiter.sv | 92 +++++++++
 tb/tb_cntb_arbiter.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/cntb_arbiter.sv
// cntb_arbiter: round-robin sharing of one bit-run counter among NUM_REQ valid/ready requesters
module cntb_arbiter #(
  parameter int NUM_REQ = 2,
  parameter int TIMEOUT = 15
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic [NUM_REQ-1:0]   req_valid_i,
  output logic [NUM_REQ-1:0]   req_ready_o,
  input  logic [NUM_REQ*32-1:0] req_word_i,
  input  logic [NUM_REQ*5-1:0] req_index_i,
  output logic [NUM_REQ-1:0]   rsp_valid_o,
  input  logic [NUM_REQ-1:0]   rsp_ready_i,
  output logic [4:0]           rsp_result_o,
  output logic                 rsp_error_o,
  output logic                 cntb_start_o,
  output logic [31:0]          cntb_word_o,
  output logic [4:0]           cntb_index_o,
  input  logic [4:0]           cntb_result_i,
  input  logic                 cntb_done_i,
  output logic                 busy_o
);
  localparam logic [1:0] IDLE = 2'd0, ISSUE = 2'd1, WAIT = 2'd2, RESP = 2'd3;
  localparam int GW = $clog2(NUM_REQ);
  logic [1:0]    state;
  logic [GW-1:0] last_grant, grant, pick;
  logic [GW-1:0] cand [NUM_REQ];
  logic          any_req;
  logic [7:0]    wdog;
  logic [31:0]   word_q;
  logic [4:0]    index_q, result_q;
  logic          error_q;
  // cand[i] is the requester i+1 places after last_grant; scanning high to low leaves the nearest one
  always_comb begin
    for (int i = 0; i < NUM_REQ; i++) cand[i] = GW'((int'(last_grant) + i + 1) % NUM_REQ);
    pick = last_grant;
    any_req = 1'b0;
    for (int i = NUM_REQ - 1; i >= 0; i--)
      if (req_valid_i[cand[i]]) begin
        pick = cand[i];
        any_req = 1'b1;
      end
  end
  assign req_ready_o  = (state == IDLE && any_req) ? NUM_REQ'(1) << pick : '0;
  assign rsp_valid_o  = state == RESP ? NUM_REQ'(1) << grant : '0;
  assign rsp_result_o = state == RESP ? result_q : '0;
  assign rsp_error_o  = state == RESP ? error_q : 1'b0;
  assign cntb_start_o = state == ISSUE;
  assign cntb_word_o  = word_q;
  assign cntb_index_o = index_q;
  assign busy_o       = state != IDLE;
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state      <= IDLE;
      last_grant <= GW'(NUM_REQ - 1);
      grant      <= '0;
      wdog       <= '0;
      word_q     <= '0;
      index_q    <= '0;
      result_q   <= '0;
      error_q    <= 1'b0;
    end else begin
      case (state)
        IDLE: if (any_req) begin
          grant   <= pick;
          word_q  <= req_word_i[32*pick +: 32];
          index_q <= req_index_i[5*pick +: 5];
          state   <= ISSUE;
        end
        ISSUE: begin
          wdog  <= '0;
          state <= WAIT;
        end
        WAIT: if (cntb_done_i) begin
          result_q <= cntb_result_i;
          error_q  <= 1'b0;
          state    <= RESP;
        end else if (wdog == 8'(TIMEOUT - 1)) begin
          result_q <= '0;
          error_q  <= 1'b1;
          state    <= RESP;
        end else begin
          wdog <= wdog + 8'd1;
        end
        RESP: if (rsp_ready_i[grant]) begin
          last_grant <= grant;
          state      <= IDLE;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_cntb_arbiter.sv
// tb_cntb_arbiter: randomized and directed scoreboard bench with a behavioural counter stub and arbitration model
module tb_cntb_arbiter;
  localparam int N = 3;
  localparam int TO = 15;
  typedef struct { int r; logic [4:0] res; logic err; int cyc; } item_t;
  logic clk_i, rst_ni;
  logic [N-1:0] req_valid_i, req_ready_o, rsp_valid_o, rsp_ready_i;
  logic [N*32-1:0] req_word_i;
  logic [N*5-1:0] req_index_i;
  logic [4:0] rsp_result_o, cntb_index_o, cntb_result_i;
  logic rsp_error_o, cntb_start_o, cntb_done_i, busy_o;
  logic [31:0] cntb_word_o;
  cntb_arbiter #(.NUM_REQ(N), .TIMEOUT(TO)) dut (
    .clk_i(clk_i), .rst_ni(rst_ni), .req_valid_i(req_valid_i), .req_ready_o(req_ready_o),
    .req_word_i(req_word_i), .req_index_i(req_index_i), .rsp_valid_o(rsp_valid_o),
    .rsp_ready_i(rsp_ready_i), .rsp_result_o(rsp_result_o), .rsp_error_o(rsp_error_o),
    .cntb_start_o(cntb_start_o), .cntb_word_o(cntb_word_o), .cntb_index_o(cntb_index_o),
    .cntb_result_i(cntb_result_i), .cntb_done_i(cntb_done_i), .busy_o(busy_o));
  int n_vec = 0, n_err = 0, cyc = 0;
  item_t sq[$];
  int glog[$];
  logic [N-1:0] pend = '0, rdy_val = '1;
  logic [31:0] pw [N];
  logic [4:0] pi [N];
  logic rst_val = 1'b0, stub_on = 1'b1, late_done = 1'b0, spur_en = 1'b0, rdy_rand = 1'b0;
  logic refill = 1'b0, gen_en = 1'b0, fair_log = 1'b0, after_rst = 1'b0, start_seen = 1'b0;
  logic [31:0] sw;
  logic [4:0] si;
  logic m_busy = 1'b0;
  int m_g = 0, m_last = N - 1, m_acc = 0, m_resp = 0;
  logic [31:0] m_w;
  logic [4:0] m_i;
  initial begin
    clk_i = 1'b0;
    forever #5 clk_i = ~clk_i;
  end
  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask
  // length of the run of bits just below idx that match bit idx
  function automatic logic [4:0] bitrun(input logic [31:0] w, input logic [4:0] idx);
    int n = 0;
    for (int j = int'(idx) - 1; j >= 0; j--) begin
      if (w[j] != w[idx]) break;
      n++;
    end
    return 5'(n);
  endfunction
  task automatic set_req(input int k, input logic [31:0] w, input logic [4:0] idx);
    pend[k] = 1'b1;
    pw[k] = w;
    pi[k] = idx;
  endtask
  task automatic step();
    int g;
    logic found;
    @(posedge clk_i);
    #1;
    cyc++;
    for (int k = 0; k < N; k++)
      if (!pend[k] && (refill || (gen_en && $urandom_range(99) < 40))) set_req(k, $urandom, 5'($urandom));
    for (int k = 0; k < N; k++) begin
      req_valid_i[k] = pend[k];
      req_word_i[32*k +: 32] = pw[k];
      req_index_i[5*k +: 5] = pi[k];
    end
    rsp_ready_i = rdy_rand ? N'($urandom) : rdy_val;
    cntb_done_i = (start_seen && stub_on) || late_done ||
                  (spur_en && $urandom_range(3) == 0 && (!m_busy || cyc >= m_resp));
    cntb_result_i = (start_seen && stub_on) ? bitrun(sw, si) : 5'($urandom);
    rst_ni = rst_val;
    @(negedge clk_i);
    if (!rst_val) begin
      m_busy = 1'b0;
      m_last = N - 1;
      sq.delete();
      start_seen = 1'b0;
      after_rst = 1'b1;
    end else begin
      if (after_rst)
        chk("post_reset_outputs", {req_ready_o, rsp_valid_o, rsp_result_o, rsp_error_o,
            cntb_start_o, cntb_word_o, cntb_index_o, busy_o}, 64'd0);
      after_rst = 1'b0;
      chk("busy", busy_o, m_busy);
      chk("start_pulse", cntb_start_o, m_busy && cyc == m_acc + 1);
      found = 1'b0;
      g = 0;
      if (!m_busy)
        for (int i = 1; i <= N; i++)
          if (!found && pend[(m_last + i) % N]) begin
            g = (m_last + i) % N;
            found = 1'b1;
          end
      chk("req_ready", req_ready_o, found ? 64'(1 << g) : 64'd0);
      if (m_busy) begin
        chk("cntb_word", cntb_word_o, m_w);
        chk("cntb_index", cntb_index_o, m_i);
      end
      chk("rsp_valid_timing", rsp_valid_o, (m_busy && cyc >= m_resp) ? 64'(1 << m_g) : 64'd0);
      start_seen = cntb_start_o;
      sw = cntb_word_o;
      si = cntb_index_o;
      if (found) begin
        m_busy = 1'b1;
        m_g = g;
        m_acc = cyc;
        m_w = pw[g];
        m_i = pi[g];
        m_resp = cyc + (stub_on ? 3 : TO + 2);
        sq.push_back('{g, stub_on ? bitrun(pw[g], pi[g]) : 5'd0, !stub_on, m_resp});
        pend[g] = 1'b0;
        if (fair_log) glog.push_back(g);
      end else if (m_busy && cyc >= m_resp && rsp_ready_i[m_g]) begin
        m_busy = 1'b0;
        m_last = m_g;
      end
    end
  endtask
  task automatic drain(input int lim);
    int n = 0;
    do begin
      step();
      n++;
    end while ((m_busy || pend != '0) && n < lim);
    chk("drain_in_time", n < lim, 1);
  endtask
  initial begin : monitor
    logic hold = 1'b0;
    logic [N-1:0] h_v;
    logic [4:0] h_r;
    logic h_e;
    forever begin
      @(negedge clk_i);
      if (!rst_ni) hold = 1'b0;
      else if (rsp_valid_o != '0) begin
        if (hold) begin
          chk("rsp_hold_valid", rsp_valid_o, h_v);
          chk("rsp_hold_result", rsp_result_o, h_r);
          chk("rsp_hold_error", rsp_error_o, h_e);
        end else if (sq.size() == 0) chk("rsp_unexpected", rsp_valid_o, 0);
        else begin
          chk("rsp_requester", rsp_valid_o, 64'(1 << sq[0].r));
          chk("rsp_result", rsp_result_o, sq[0].res);
          chk("rsp_error", rsp_error_o, sq[0].err);
          chk("rsp_latency", cyc, sq[0].cyc);
        end
        if ((rsp_valid_o & rsp_ready_i) != '0) begin
          hold = 1'b0;
          if (sq.size() > 0) sq.delete(0);
        end else begin
          hold = 1'b1;
          h_v = rsp_valid_o;
          h_r = rsp_result_o;
          h_e = rsp_error_o;
        end
      end else begin
        chk("rsp_idle_zero", {rsp_result_o, rsp_error_o}, 0);
        if (hold) chk("rsp_dropped", rsp_valid_o, h_v);
        hold = 1'b0;
      end
    end
  end
  initial begin
    int hold_cnt;
    int n;
    req_valid_i = '0; req_word_i = '0; req_index_i = '0; rsp_ready_i = '0;
    cntb_done_i = 1'b0; cntb_result_i = '0; rst_ni = 1'b0;
    repeat (2) step();
    rst_val = 1'b1;
    step();
    set_req(0, 32'h0000_0782, 5'd5);
    set_req(1, 32'hFFFF_FFFF, 5'd31);
    drain(30);
    set_req(0, 32'h0000_000E, 5'd3);
    drain(20);
    set_req(2, $urandom, 5'($urandom));
    drain(20);
    refill = 1'b1;
    fair_log = 1'b1;
    n = 0;
    while (glog.size() < 9 && n < 80) begin
      step();
      n++;
    end
    refill = 1'b0;
    fair_log = 1'b0;
    drain(40);
    chk("fair_count", glog.size() >= 9, 1);
    for (int i = 0; i < 9 && i < glog.size(); i++) chk("fair_order", glog[i], i % 3);
    rdy_val = '0;
    set_req(0, $urandom, 5'($urandom));
    step();
    set_req(1, $urandom, 5'($urandom));
    hold_cnt = 0;
    repeat (7) begin
      step();
      if (rsp_valid_o == 3'b001) hold_cnt++;
    end
    chk("bp_hold_cycles", hold_cnt, 5);
    rdy_val = '1;
    drain(20);
    stub_on = 1'b0;
    rdy_val = '0;
    set_req(0, $urandom, 5'($urandom));
    repeat (18) step();
    late_done = 1'b1;
    step();
    late_done = 1'b0;
    step();
    rdy_val = '1;
    drain(20);
    set_req(0, $urandom, 5'($urandom));
    repeat (3) step();
    rst_val = 1'b0;
    step();
    rst_val = 1'b1;
    stub_on = 1'b1;
    step();
    set_req(0, $urandom, 5'($urandom));
    set_req(1, $urandom, 5'($urandom));
    step();
    chk("reset_grant0", req_ready_o, 1);
    drain(30);
    gen_en = 1'b1;
    spur_en = 1'b1;
    rdy_rand = 1'b1;
    repeat (400) step();
    gen_en = 1'b0;
    rdy_rand = 1'b0;
    rdy_val = '1;
    drain(100);
    spur_en = 1'b0;
    repeat (2) step();
    chk("scoreboard_empty", sq.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
